// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with optional 2-entry skid buffer, flush and freeze
module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] INIT = {WIDTH{1'b0}},
  parameter bit SKID = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] main, main_n, skid, skid_n;
  logic in_fire, out_fire;
  // The skid build decodes in_ready from state alone, cutting the out_ready path
  assign in_ready = SKID ? (state != FULL) : ((state == EMPTY) | (out_ready & ena));
  assign in_fire = in_valid & in_ready & ena & ~flush;
  assign out_fire = out_valid & out_ready & ena;
  assign out_valid = state != EMPTY;
  assign out_data = main;
  assign level = state;
  always_comb begin
    state_n = state;
    main_n = main;
    skid_n = skid;
    if (flush) begin
      state_n = EMPTY;
      main_n = INIT;
      skid_n = INIT;
    end else if (ena) begin
      case (state)
        EMPTY: begin
          state_n = in_fire ? ONE : EMPTY;
          main_n = in_fire ? in_data : main;
        end
        ONE: begin
          state_n = (in_fire & ~out_fire & SKID) ? FULL : (out_fire & ~in_fire) ? EMPTY : ONE;
          main_n = (in_fire & out_fire) ? in_data : main;
          skid_n = (in_fire & ~out_fire & SKID) ? in_data : skid;
        end
        FULL: begin
          state_n = out_fire ? ONE : FULL;
          main_n = out_fire ? skid : main;
        end
        default: state_n = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= EMPTY;
      main <= INIT;
    end else begin
      state <= state_n;
      main <= main_n;
    end
  if (SKID) begin : g_skid
    always_ff @(posedge clk or negedge rst)
      if (!rst) skid <= INIT;
      else skid <= skid_n;
  end else begin : g_noskid
    assign skid = INIT;
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vector bench for the skid and single-entry builds
module tb_pipe_stage_reg;
  localparam logic [31:0] IA = 32'hDEADBEEF;
  logic clk = 0;
  always #5 clk = ~clk;
  logic a_rst = 0, a_ena = 1, a_flush = 0, a_iv = 0, a_ordy = 0;
  logic [31:0] a_d = 0, a_od;
  logic a_ir, a_ov;
  logic [1:0] a_lv;
  logic b_rst = 0, b_ena = 1, b_flush = 0, b_iv = 0, b_ordy = 0;
  logic [31:0] b_d = 0, b_od;
  logic b_ir, b_ov;
  logic [1:0] b_lv;
  int checks = 0, errors = 0;
  pipe_stage_reg #(.WIDTH(32), .INIT(IA), .SKID(1'b1)) dut_a (
    .clk(clk), .rst(a_rst), .ena(a_ena), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ir),
    .in_data(a_d), .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_od), .level(a_lv));
  pipe_stage_reg #(.WIDTH(32), .SKID(1'b0)) dut_b (
    .clk(clk), .rst(b_rst), .ena(b_ena), .flush(b_flush), .in_valid(b_iv), .in_ready(b_ir),
    .in_data(b_d), .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_od), .level(b_lv));
  typedef struct {
    bit u; bit en; bit fl; bit iv; logic [31:0] d; bit ordy;
    bit eir; logic [1:0] elv; bit eov; logic [31:0] eod;
  } vec_t;
  vec_t v[$];
  function automatic vec_t mk(bit u, bit en, bit fl, bit iv, logic [31:0] d, bit ordy,
                              bit eir, logic [1:0] elv, bit eov, logic [31:0] eod);
    vec_t x;
    x.u = u; x.en = en; x.fl = fl; x.iv = iv; x.d = d; x.ordy = ordy;
    x.eir = eir; x.elv = elv; x.eov = eov; x.eod = eod;
    return x;
  endfunction
  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, i, act, exp);
    end
  endtask
  task automatic run(vec_t x, int i);
    @(negedge clk);
    if (!x.u) begin
      a_ena = x.en; a_flush = x.fl; a_iv = x.iv; a_d = x.d; a_ordy = x.ordy;
    end else begin
      b_ena = x.en; b_flush = x.fl; b_iv = x.iv; b_d = x.d; b_ordy = x.ordy;
    end
    #1;
    chk("in_ready", i, 32'(x.u ? b_ir : a_ir), 32'(x.eir));
    @(posedge clk);
    #1;
    chk("level", i, 32'(x.u ? b_lv : a_lv), 32'(x.elv));
    chk("out_valid", i, 32'(x.u ? b_ov : a_ov), 32'(x.eov));
    chk("out_data", i, x.u ? b_od : a_od, x.eod);
  endtask
  initial begin
    #12;
    chk("rst_level", 0, 32'(a_lv), 0);
    chk("rst_out_valid", 0, 32'(a_ov), 0);
    chk("rst_out_data", 0, a_od, IA);
    chk("rst_in_ready", 0, 32'(a_ir), 1);
    chk("rst_b_out_data", 0, b_od, 0);
    @(negedge clk);
    a_rst = 1; b_rst = 1;
    // streaming 1..8, then drain
    for (int k = 1; k <= 8; k++) v.push_back(mk(0, 1, 0, 1, k, 1, 1, 1, 1, k));
    v.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 8));
    // backpressure: A, B fill; C refused; drain in order A, B, C
    v.push_back(mk(0, 1, 0, 1, 'hA, 0, 1, 1, 1, 'hA));
    v.push_back(mk(0, 1, 0, 1, 'hB, 0, 1, 2, 1, 'hA));
    v.push_back(mk(0, 1, 0, 1, 'hC, 0, 0, 2, 1, 'hA));
    v.push_back(mk(0, 1, 0, 1, 'hC, 1, 0, 1, 1, 'hB));
    v.push_back(mk(0, 1, 0, 1, 'hC, 1, 1, 1, 1, 'hC));
    v.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 'hC));
    // flush from FULL with a word offered
    v.push_back(mk(0, 1, 0, 1, 'h11, 0, 1, 1, 1, 'h11));
    v.push_back(mk(0, 1, 0, 1, 'h22, 0, 1, 2, 1, 'h11));
    v.push_back(mk(0, 1, 1, 1, 'h33, 0, 0, 0, 0, IA));
    v.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, IA));
    // freeze for 5 cycles, then resume
    v.push_back(mk(0, 1, 0, 1, 'h55, 0, 1, 1, 1, 'h55));
    for (int k = 0; k < 5; k++) v.push_back(mk(0, 0, 0, 1, 'h66, 1, 1, 1, 1, 'h55));
    v.push_back(mk(0, 1, 0, 1, 'h66, 1, 1, 1, 1, 'h66));
    v.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 'h66));
    // flush wins over freeze
    v.push_back(mk(0, 1, 0, 1, 'h77, 0, 1, 1, 1, 'h77));
    v.push_back(mk(0, 0, 1, 1, 'h88, 1, 1, 0, 0, IA));
    // FULL holds while out_ready stays low
    v.push_back(mk(0, 1, 0, 1, 'h91, 0, 1, 1, 1, 'h91));
    v.push_back(mk(0, 1, 0, 1, 'h92, 0, 1, 2, 1, 'h91));
    for (int k = 0; k < 4; k++) v.push_back(mk(0, 1, 0, k[0], 'h93, 0, 0, 2, 1, 'h91));
    // single-entry build: exchange in one cycle
    v.push_back(mk(1, 1, 0, 1, 'h7, 0, 1, 1, 1, 'h7));
    v.push_back(mk(1, 1, 0, 1, 'h8, 0, 0, 1, 1, 'h7));
    v.push_back(mk(1, 0, 0, 1, 'h8, 1, 0, 1, 1, 'h7));
    v.push_back(mk(1, 1, 0, 1, 'h8, 1, 1, 1, 1, 'h8));
    v.push_back(mk(1, 1, 0, 1, 'h9, 1, 1, 1, 1, 'h9));
    v.push_back(mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 'h9));
    foreach (v[i]) run(v[i], i);
    // asynchronous reset while FULL, between clock edges
    @(negedge clk);
    #1 a_rst = 0;
    #1;
    chk("arst_level", 0, 32'(a_lv), 0);
    chk("arst_out_valid", 0, 32'(a_ov), 0);
    chk("arst_out_data", 0, a_od, IA);
    chk("arst_in_ready", 0, 32'(a_ir), 1);
    @(negedge clk);
    a_rst = 1; a_iv = 1; a_d = 'hAB; a_ordy = 0;
    @(posedge clk);
    #1;
    chk("post_rst_data", 0, a_od, 'hAB);
    chk("post_rst_level", 0, 32'(a_lv), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
